// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, reads a 1-cycle-latency imem, and feeds decode via an output reg plus a 1-entry skid.
// Define FETCH_PERF_EN to add the perf_fetched / perf_stall counters.
module fetch_stage #(
  parameter int                XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = 32'h0000_0000,
  parameter logic [31:0]       NOP_INSN = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_en,
  output logic            imem_en,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            insn_valid,
  input  logic            insn_ready,
  output logic [31:0]     insn_out,
  output logic [XLEN-1:0] pc_out
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall
`endif
);

  typedef enum logic [1:0] {BOOT, RUN, SKID} state_t;

  state_t          r_state;
  state_t          w_stateNext;

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_reqPc;
  logic            r_inflight;

  logic            r_outValid;
  logic [31:0]     r_outInsn;
  logic [XLEN-1:0] r_outPc;

  logic            r_skidValid;
  logic [31:0]     r_skidInsn;
  logic [XLEN-1:0] r_skidPc;

  logic            w_consume;
  logic            w_resp;
  logic            w_issue;
  logic            w_outFree;

  assign w_consume = r_outValid && insn_ready;
  assign w_resp    = r_inflight;
  assign w_outFree = !r_outValid || w_consume;

  // Hold off a request whose response would find both out-reg and skid occupied.
  assign w_issue = (r_state == RUN) && fetch_en && !redirect_valid &&
                   !(r_inflight && r_outValid && !insn_ready);

  assign imem_en    = w_issue;
  assign imem_addr  = r_pc;
  assign insn_valid = r_outValid;
  assign insn_out   = r_outValid ? r_outInsn : NOP_INSN;
  assign pc_out     = r_outPc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      BOOT: w_stateNext = RUN;
      RUN:  if (w_resp && r_outValid && !insn_ready) w_stateNext = SKID;
      SKID: if (w_consume) w_stateNext = RUN;
      default: w_stateNext = BOOT;
    endcase
    if (redirect_valid) begin
      w_stateNext = RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc        <= {RESET_PC[XLEN-1:2], 2'b00};
      r_reqPc     <= '0;
      r_inflight  <= 1'b0;
      r_outValid  <= 1'b0;
      r_outInsn   <= NOP_INSN;
      r_outPc     <= '0;
      r_skidValid <= 1'b0;
      r_skidInsn  <= NOP_INSN;
      r_skidPc    <= '0;
    end else if (redirect_valid) begin
      r_pc        <= {redirect_pc[XLEN-1:2], 2'b00};
      r_inflight  <= 1'b0;
      r_outValid  <= 1'b0;
      r_outInsn   <= NOP_INSN;
      r_skidValid <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_pc    <= r_pc + XLEN'(4);
        r_reqPc <= r_pc;
      end
      // Skid drains first so program order is preserved.
      if (r_skidValid && w_outFree) begin
        r_outValid  <= 1'b1;
        r_outInsn   <= r_skidInsn;
        r_outPc     <= r_skidPc;
        r_skidValid <= w_resp;
        if (w_resp) begin
          r_skidInsn <= imem_rdata;
          r_skidPc   <= r_reqPc;
        end
      end else if (w_resp && w_outFree) begin
        r_outValid <= 1'b1;
        r_outInsn  <= imem_rdata;
        r_outPc    <= r_reqPc;
      end else if (w_resp) begin
        r_skidValid <= 1'b1;
        r_skidInsn  <= imem_rdata;
        r_skidPc    <= r_reqPc;
      end else if (w_consume) begin
        r_outValid <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_perfFetched;
  logic [31:0] r_perfStall;

  // A transfer coinciding with a redirect still counts as accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perfFetched <= '0;
      r_perfStall   <= '0;
    end else begin
      if (r_outValid && insn_ready) r_perfFetched <= r_perfFetched + 32'd1;
      if (r_outValid && !insn_ready) r_perfStall <= r_perfStall + 32'd1;
    end
  end

  assign perf_fetched = r_perfFetched;
  assign perf_stall   = r_perfStall;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a 1-cycle-latency imem model.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fetchEn = 1'b1;
   logic        imemEn;
   logic [31:0] imemAddr;
   logic [31:0] imemRdata = 32'h0;
   logic        redirectValid = 1'b0;
   logic [31:0] redirectPc = 32'h0;
   logic        insnValid;
   logic        insnReady = 1'b1;
   logic [31:0] insnOut;
   logic [31:0] pcOut;
`ifdef FETCH_PERF_EN
   logic [31:0] perfFetched;
   logic [31:0] perfStall;
`endif

   int compared = 0;
   int failed = 0;

   localparam logic [31:0] NOP = 32'h0000_0013;

   fetch_stage dut (
      .clk(clk),
      .rst(rst),
      .fetch_en(fetchEn),
      .imem_en(imemEn),
      .imem_addr(imemAddr),
      .imem_rdata(imemRdata),
      .redirect_valid(redirectValid),
      .redirect_pc(redirectPc),
      .insn_valid(insnValid),
      .insn_ready(insnReady),
      .insn_out(insnOut),
      .pc_out(pcOut)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetched(perfFetched),
      .perf_stall(perfStall)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memWord(input logic [31:0] a);
      case (a)
         32'h0: memWord = 32'h00A0_0093;
         32'h4: memWord = 32'h0010_0113;
         default: memWord = {a[31:2], 2'b11} ^ 32'h5A00_0000;
      endcase
   endfunction

   // Synchronous instruction memory, data one cycle after the request.
   always @(posedge clk) begin
      if (imemEn) imemRdata <= memWord(imemAddr);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; fetchEn = 1'b1; insnReady = 1'b1; redirectValid = 1'b0;
      tick(); tick();
      compared++; if (insnValid !== 1'b0) begin failed++; $display("[TB] FAIL reset_valid got %0h want 0", insnValid); end
      compared++; if (imemEn !== 1'b0) begin failed++; $display("[TB] FAIL reset_imem_en got %0h want 0", imemEn); end
      compared++; if (insnOut !== NOP) begin failed++; $display("[TB] FAIL reset_insn got %h want %h", insnOut, NOP); end
      compared++; if (pcOut !== 32'h0) begin failed++; $display("[TB] FAIL reset_pc got %h want 0", pcOut); end
`ifdef FETCH_PERF_EN
      compared++; if (perfFetched !== 32'h0) begin failed++; $display("[TB] FAIL reset_perf_fetched got %0d want 0", perfFetched); end
`endif
      rst = 1'b0;
      #1;
      compared++; if (imemEn !== 1'b0) begin failed++; $display("[TB] FAIL boot_no_req got %0h want 0", imemEn); end
   endtask

   task automatic test_throughput();
      tick();
      compared++; if (imemEn !== 1'b1 || imemAddr !== 32'h0) begin failed++; $display("[TB] FAIL tp_req0 got en=%0h addr=%h want en=1 addr=0", imemEn, imemAddr); end
      compared++; if (insnValid !== 1'b0) begin failed++; $display("[TB] FAIL tp_valid_e1 got %0h want 0", insnValid); end
      tick();
      compared++; if (imemEn !== 1'b1 || imemAddr !== 32'h4) begin failed++; $display("[TB] FAIL tp_req4 got en=%0h addr=%h want en=1 addr=4", imemEn, imemAddr); end
      compared++; if (insnValid !== 1'b0) begin failed++; $display("[TB] FAIL tp_valid_e2 got %0h want 0", insnValid); end
      tick();
      compared++; if (insnValid !== 1'b1 || pcOut !== 32'h0 || insnOut !== 32'h00A0_0093) begin failed++; $display("[TB] FAIL tp_first got v=%0h pc=%h insn=%h want v=1 pc=0 insn=00a00093", insnValid, pcOut, insnOut); end
      compared++; if (imemAddr !== 32'h8) begin failed++; $display("[TB] FAIL tp_addr8 got %h want 8", imemAddr); end
      tick();
      compared++; if (insnValid !== 1'b1 || pcOut !== 32'h4 || insnOut !== 32'h0010_0113) begin failed++; $display("[TB] FAIL tp_second got v=%0h pc=%h insn=%h want v=1 pc=4 insn=00100113", insnValid, pcOut, insnOut); end
      tick();
      compared++; if (insnValid !== 1'b1 || pcOut !== 32'h8 || insnOut !== memWord(32'h8)) begin failed++; $display("[TB] FAIL tp_third got v=%0h pc=%h insn=%h want v=1 pc=8", insnValid, pcOut, insnOut); end
   endtask

   task automatic test_stall();
      insnReady = 1'b0;
      #1;
      compared++; if (imemEn !== 1'b0) begin failed++; $display("[TB] FAIL stall_no_req got %0h want 0", imemEn); end
      for (int i = 0; i < 3; i++) begin
         tick();
         compared++; if (imemEn !== 1'b0) begin failed++; $display("[TB] FAIL stall_imem_en_%0d got %0h want 0", i, imemEn); end
         compared++; if (insnValid !== 1'b1 || pcOut !== 32'h8 || insnOut !== memWord(32'h8)) begin failed++; $display("[TB] FAIL stall_hold_%0d got v=%0h pc=%h want v=1 pc=8", i, insnValid, pcOut); end
      end
      insnReady = 1'b1;
      #1;
      compared++; if (imemEn !== 1'b0) begin failed++; $display("[TB] FAIL skid_no_req got %0h want 0", imemEn); end
      tick();
      compared++; if (insnValid !== 1'b1 || pcOut !== 32'hC || insnOut !== memWord(32'hC)) begin failed++; $display("[TB] FAIL skid_out got v=%0h pc=%h want v=1 pc=c", insnValid, pcOut); end
      compared++; if (imemEn !== 1'b1 || imemAddr !== 32'h10) begin failed++; $display("[TB] FAIL resume_req got en=%0h addr=%h want en=1 addr=10", imemEn, imemAddr); end
      tick();
      compared++; if (insnValid !== 1'b0) begin failed++; $display("[TB] FAIL resume_bubble got %0h want 0", insnValid); end
      tick();
      compared++; if (insnValid !== 1'b1 || pcOut !== 32'h10) begin failed++; $display("[TB] FAIL resume_pc10 got v=%0h pc=%h want v=1 pc=10", insnValid, pcOut); end
      tick();
      compared++; if (insnValid !== 1'b1 || pcOut !== 32'h14) begin failed++; $display("[TB] FAIL resume_pc14 got v=%0h pc=%h want v=1 pc=14", insnValid, pcOut); end
   endtask

   task automatic test_redirect();
      redirectValid = 1'b1; redirectPc = 32'h0000_0103;
      #1;
      compared++; if (imemEn !== 1'b0) begin failed++; $display("[TB] FAIL redir_no_req got %0h want 0", imemEn); end
      tick();
      redirectValid = 1'b0;
      #1;
      compared++; if (insnValid !== 1'b0 || insnOut !== NOP) begin failed++; $display("[TB] FAIL redir_flush got v=%0h insn=%h want v=0 insn=%h", insnValid, insnOut, NOP); end
      compared++; if (imemEn !== 1'b1 || imemAddr !== 32'h100) begin failed++; $display("[TB] FAIL redir_target_req got en=%0h addr=%h want en=1 addr=100", imemEn, imemAddr); end
      tick();
      compared++; if (insnValid !== 1'b0) begin failed++; $display("[TB] FAIL redir_drop_inflight got %0h want 0", insnValid); end
      tick();
      compared++; if (insnValid !== 1'b1 || pcOut !== 32'h100 || insnOut !== memWord(32'h100)) begin failed++; $display("[TB] FAIL redir_first got v=%0h pc=%h insn=%h want v=1 pc=100", insnValid, pcOut, insnOut); end
   endtask

   task automatic test_redirect_skid();
      insnReady = 1'b0;
      tick();
      compared++; if (imemEn !== 1'b0 || insnValid !== 1'b1 || pcOut !== 32'h100) begin failed++; $display("[TB] FAIL rs_stall got en=%0h v=%0h pc=%h want en=0 v=1 pc=100", imemEn, insnValid, pcOut); end
      redirectValid = 1'b1; redirectPc = 32'h0000_0200;
      tick();
      redirectValid = 1'b0; insnReady = 1'b1;
      #1;
      compared++; if (insnValid !== 1'b0 || insnOut !== NOP) begin failed++; $display("[TB] FAIL rs_flush got v=%0h insn=%h want v=0", insnValid, insnOut); end
      compared++; if (imemEn !== 1'b1 || imemAddr !== 32'h200) begin failed++; $display("[TB] FAIL rs_run_req got en=%0h addr=%h want en=1 addr=200", imemEn, imemAddr); end
      tick();
      compared++; if (insnValid !== 1'b0) begin failed++; $display("[TB] FAIL rs_skid_cleared got %0h want 0", insnValid); end
      tick();
      compared++; if (insnValid !== 1'b1 || pcOut !== 32'h200 || insnOut !== memWord(32'h200)) begin failed++; $display("[TB] FAIL rs_first got v=%0h pc=%h want v=1 pc=200", insnValid, pcOut); end
   endtask

   task automatic test_wrap();
      redirectValid = 1'b1; redirectPc = 32'hFFFF_FFF8;
      tick();
      redirectValid = 1'b0;
      #1;
      compared++; if (imemEn !== 1'b1 || imemAddr !== 32'hFFFF_FFF8) begin failed++; $display("[TB] FAIL wrap_req got en=%0h addr=%h want en=1 addr=fffffff8", imemEn, imemAddr); end
      tick();
      tick();
      compared++; if (insnValid !== 1'b1 || pcOut !== 32'hFFFF_FFF8) begin failed++; $display("[TB] FAIL wrap_pc0 got v=%0h pc=%h want v=1 pc=fffffff8", insnValid, pcOut); end
      compared++; if (imemAddr !== 32'h0) begin failed++; $display("[TB] FAIL wrap_addr got %h want 0", imemAddr); end
      tick();
      compared++; if (insnValid !== 1'b1 || pcOut !== 32'hFFFF_FFFC) begin failed++; $display("[TB] FAIL wrap_pc1 got v=%0h pc=%h want v=1 pc=fffffffc", insnValid, pcOut); end
      tick();
      compared++; if (insnValid !== 1'b1 || pcOut !== 32'h0 || insnOut !== 32'h00A0_0093) begin failed++; $display("[TB] FAIL wrap_pc2 got v=%0h pc=%h insn=%h want v=1 pc=0 insn=00a00093", insnValid, pcOut, insnOut); end
   endtask

   task automatic test_fetch_en();
      fetchEn = 1'b0;
      #1;
      compared++; if (imemEn !== 1'b0) begin failed++; $display("[TB] FAIL fe_no_req got %0h want 0", imemEn); end
      tick();
      compared++; if (insnValid !== 1'b1 || pcOut !== 32'h4 || insnOut !== 32'h0010_0113) begin failed++; $display("[TB] FAIL fe_inflight_lands got v=%0h pc=%h want v=1 pc=4", insnValid, pcOut); end
      tick();
      compared++; if (insnValid !== 1'b0 || imemEn !== 1'b0) begin failed++; $display("[TB] FAIL fe_drained got v=%0h en=%0h want v=0 en=0", insnValid, imemEn); end
      fetchEn = 1'b1;
      #1;
      compared++; if (imemEn !== 1'b1 || imemAddr !== 32'h8) begin failed++; $display("[TB] FAIL fe_resume got en=%0h addr=%h want en=1 addr=8", imemEn, imemAddr); end
   endtask

   task automatic test_reset_mid();
      insnReady = 1'b0;
      tick();
      compared++; if (imemEn !== 1'b1 || imemAddr !== 32'hC) begin failed++; $display("[TB] FAIL rm_req_c got en=%0h addr=%h want en=1 addr=c", imemEn, imemAddr); end
      tick();
      compared++; if (imemEn !== 1'b0 || insnValid !== 1'b1 || pcOut !== 32'h8) begin failed++; $display("[TB] FAIL rm_out8 got en=%0h v=%0h pc=%h want en=0 v=1 pc=8", imemEn, insnValid, pcOut); end
      tick();
      compared++; if (insnValid !== 1'b1 || pcOut !== 32'h8) begin failed++; $display("[TB] FAIL rm_skid_full got v=%0h pc=%h want v=1 pc=8", insnValid, pcOut); end
      #2;
      rst = 1'b1;
      #1;
      compared++; if (insnValid !== 1'b0 || imemEn !== 1'b0) begin failed++; $display("[TB] FAIL rm_async got v=%0h en=%0h want v=0 en=0", insnValid, imemEn); end
      compared++; if (insnOut !== NOP || pcOut !== 32'h0) begin failed++; $display("[TB] FAIL rm_async_vals got insn=%h pc=%h want insn=%h pc=0", insnOut, pcOut, NOP); end
`ifdef FETCH_PERF_EN
      compared++; if (perfFetched !== 32'h0 || perfStall !== 32'h0) begin failed++; $display("[TB] FAIL rm_perf got f=%0d s=%0d want 0 0", perfFetched, perfStall); end
`endif
      tick();
      rst = 1'b0; insnReady = 1'b1;
      #1;
      compared++; if (imemEn !== 1'b0) begin failed++; $display("[TB] FAIL rm_boot got %0h want 0", imemEn); end
      tick();
      compared++; if (imemEn !== 1'b1 || imemAddr !== 32'h0) begin failed++; $display("[TB] FAIL rm_refetch got en=%0h addr=%h want en=1 addr=0", imemEn, imemAddr); end
      tick();
      compared++; if (insnValid !== 1'b0) begin failed++; $display("[TB] FAIL rm_no_stale got %0h want 0", insnValid); end
      tick();
      compared++; if (insnValid !== 1'b1 || pcOut !== 32'h0 || insnOut !== 32'h00A0_0093) begin failed++; $display("[TB] FAIL rm_first got v=%0h pc=%h insn=%h want v=1 pc=0", insnValid, pcOut, insnOut); end
   endtask

   initial begin
      test_reset();
      test_throughput();
      test_stall();
      test_redirect();
      test_redirect_skid();
      test_wrap();
      test_fetch_en();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage; sits directly upstream of the instruction decoder. Owns the PC and issues word reads to a synchronous instruction memory with 1-cycle read latency. Presents {insn, pc} to decode through a valid/ready output register backed by a 1-entry skid register. Accepts taken-branch redirects from execute.

Parameters:
XLEN, 32, PC/address width in bits
RESET_PC, 32'h0000_0000, first fetch address after reset; must be 4-byte aligned
NOP_INSN, 32'h0000_0013, value driven on insn_out when invalid (addi x0,x0,0)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
fetch_en  in  1  1 = fetching allowed; 0 = no new imem requests
imem_en  out  1  read request this cycle
imem_addr  out  XLEN  word-aligned read address; low 2 bits always 0
imem_rdata  in  32  read data, valid the cycle after imem_en=1
redirect_valid  in  1  taken branch/jump from execute
redirect_pc  in  XLEN  redirect target
insn_valid  out  1  insn_out/pc_out hold a live instruction
insn_ready  in  1  decoder accepts; transfer when insn_valid && insn_ready
insn_out  out  32  instruction to decoder
pc_out  out  XLEN  address of insn_out

Behaviour:
- Reset (async assert): pc=RESET_PC, imem_en=0, inflight=0, skid empty, insn_valid=0, insn_out=NOP_INSN, pc_out=0, state=BOOT.
- States: BOOT (first cycle after reset release; no request), RUN (normal), SKID (skid full; no requests). BOOT->RUN unconditionally. RUN->SKID when a response arrives, out-reg holds a valid entry, and insn_ready=0. SKID->RUN when the out-reg is consumed; the skid entry moves into the out-reg in the same edge.
- Request rule (RUN only): imem_en=1 iff fetch_en && !redirect_valid && !(inflight && insn_valid && !insn_ready). imem_addr=pc. On issue: pc<=pc+4, mod 2^XLEN (0xFFFFFFFC wraps to 0); inflight<=1, req_pc<=pc.
- Response: when inflight=1, imem_rdata is valid this cycle. It loads the out-reg if the out-reg is empty or consumed this cycle; otherwise it loads skid. Skid always has priority over a new response for the out-reg. The request rule guarantees there is never a response with both out-reg and skid full.
- Throughput: 1 insn/cycle with insn_ready=1. First insn_valid=1 on the 3rd edge after reset release (BOOT, request, response).
- Redirect (highest priority, any state): on the edge, pc<=redirect_pc with bits [1:0] cleared. Inflight response discarded. Out-reg and skid invalidated: insn_valid=0, insn_out=NOP_INSN. State<=RUN. No request is issued in the redirect cycle. The first target insn is valid 2 edges after the redirect edge.
- Redirect with insn_valid && insn_ready in the same cycle: the transfer still counts as accepted by decode; the entry is then invalidated.
- fetch_en=0: no new requests. An inflight response still lands. Out-reg and skid drain normally.
- insn_out/pc_out hold stable while insn_valid && !insn_ready.
- Reset mid-operation: returns immediately to reset values; the inflight response is ignored.

Optional Feature:
FETCH_PERF_EN defined: adds outputs perf_fetched (32b) and perf_stall (32b), both reset to 0.
- perf_fetched increments on each accepted transfer (insn_valid && insn_ready).
- perf_stall increments on each cycle with insn_valid && !insn_ready.
- Both counters wrap at 2^32.
Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, fetch_en=1, insn_ready=1, imem returns 0x00A00093,0x00100113,... -> imem_addr 0,4,8,...; insn_valid first high on 3rd edge; pc_out 0,4,8 on consecutive cycles.
- insn_ready=0 for 3 cycles mid-stream -> one response captured in skid, imem_en=0 while stalled. On ready=1, the skid insn appears the next cycle with no loss or duplication of pc 0x10/0x14.
- redirect_valid=1, redirect_pc=0x0000_0103 with a request inflight -> inflight insn dropped; insn_valid=0 next cycle; next imem_addr=0x100; pc_out=0x100 valid 2 edges after the redirect.
- redirect in the same cycle as a skid-full stall -> skid and out-reg cleared, state RUN, fetch resumes at the target.
- redirect_pc=0xFFFF_FFF8, run 3 insns -> pc_out 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- rst asserted asynchronously mid-stall (skid full) -> insn_valid=0 and imem_en=0 immediately. After release, refetch from RESET_PC. With FETCH_PERF_EN, counters read 0.
